frame_ram_streamer: RTL and testbench

FRAME_RAM_STREAMER -- requirements
Module: frame_ram_streamer

---
 rtl/frame_ram_streamer_if.sv | 43 ++++
 rtl/frame_ram_streamer.sv | 148 ++++++++++++++
 tb/tb_frame_ram_streamer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_ram_streamer_if.sv
// frame_ram_streamer_if
//   Bundles the frame-RAM read port, the AXI-Stream master beat signals and
//   the status pulses of frame_ram_streamer.
//   master modport: the streamer.
//   slave modport:  the environment, which holds the frame RAM and the stream sink.
//   Signals:
//     Frame_Ready       env -> streamer  one-cycle pulse, a complete frame is in RAM
//     RAM_Data          env -> streamer  RAM read data, valid one cycle after the read
//     T_READY           env -> streamer  downstream ready
//     RAM_Read_Address  streamer -> env  RAM read address
//     RAM_Read_Enable   streamer -> env  RAM read enable
//     T_VALID/T_DATA/T_LAST  streamer -> env  stream beat
//     Busy              streamer -> env  a frame is in progress
//     Frame_Done        streamer -> env  one-cycle pulse after the last beat is taken
//     Frame_Dropped     streamer -> env  one-cycle pulse, Frame_Ready was ignored
interface frame_ram_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                  Frame_Ready;
  logic [DATA_WIDTH-1:0] RAM_Data;
  logic                  T_READY;
  logic [ADDR_WIDTH-1:0] RAM_Read_Address;
  logic                  RAM_Read_Enable;
  logic                  T_VALID;
  logic [DATA_WIDTH-1:0] T_DATA;
  logic                  T_LAST;
  logic                  Busy;
  logic                  Frame_Done;
  logic                  Frame_Dropped;

  modport master (
    input  Frame_Ready, RAM_Data, T_READY,
    output RAM_Read_Address, RAM_Read_Enable, T_VALID, T_DATA, T_LAST,
           Busy, Frame_Done, Frame_Dropped
  );

  modport slave (
    output Frame_Ready, RAM_Data, T_READY,
    input  RAM_Read_Address, RAM_Read_Enable, T_VALID, T_DATA, T_LAST,
           Busy, Frame_Done, Frame_Dropped
  );
endinterface

// File: rtl/frame_ram_streamer.sv
// frame_ram_streamer
//   Reads one complete frame (2**ADDR_WIDTH words) out of a frame RAM with
//   one cycle of read latency and streams it as AXI-Stream beats. Reads are
//   throttled so that returned words always fit in a two-entry output buffer
//   (output register plus skid register), so backpressure never loses data
//   while an unstalled stream still runs at one beat per cycle.
//   Ports:
//     clk      rising-edge clock
//     reset_b  synchronous reset, active high
//     bus      frame_ram_streamer_if.master (RAM read port, stream, status)
//   Parameters:
//     DATA_WIDTH   sample word width
//     ADDR_WIDTH   frame RAM address width, frame length 2**ADDR_WIDTH
//     BIT_REVERSE  1 = RAM addresses issued in bit-reversed read-counter order
module frame_ram_streamer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter bit BIT_REVERSE = 1'b0
) (
  input logic                  clk,
  input logic                  reset_b,
  frame_ram_streamer_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic                  rd_pending;
  logic                  out_valid, skid_valid;
  logic [DATA_WIDTH-1:0] out_data, skid_data;
  logic                  frame_done_q, frame_dropped_q;

  logic                  handshake, last_hs;
  logic                  rd_issue, frame_start, frame_drop;
  logic [1:0]            occupancy;

  assign handshake = out_valid & bus.T_READY;
  assign last_hs   = handshake & (beat_cnt == LAST_IDX);

  // Words held or on their way after this edge. The beat leaving on this
  // cycle's handshake frees its slot, which is what lets a read issue every
  // cycle while the sink keeps up.
  assign occupancy = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pending) - 2'(handshake);

  // NOTE: state registers take non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset_b) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    rd_issue    = 1'b0;
    frame_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.Frame_Ready) begin
          state_nxt   = FETCH;
          frame_start = 1'b1;
        end
      end
      FETCH: begin
        rd_issue = (occupancy < 2'd2);
        if (rd_issue && (rd_cnt == LAST_IDX)) state_nxt = DRAIN;
      end
      DRAIN: begin
        // A new frame arriving on the final handshake is taken directly.
        if (last_hs) begin
          if (bus.Frame_Ready) begin
            state_nxt   = FETCH;
            frame_start = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    frame_drop = bus.Frame_Ready & (state != IDLE) & ~frame_start;
  end

  // NOTE: the data registers are reset as well as the valid flags because
  // T_DATA is required to read 0 out of reset, not merely be ignored.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      rd_cnt          <= '0;
      beat_cnt        <= '0;
      rd_pending      <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      skid_valid      <= 1'b0;
      skid_data       <= '0;
      frame_done_q    <= 1'b0;
      frame_dropped_q <= 1'b0;
    end else begin
      frame_done_q    <= last_hs;
      frame_dropped_q <= frame_drop;
      rd_pending      <= rd_issue;

      if (frame_start) begin
        rd_cnt   <= '0;
        beat_cnt <= '0;
      end else begin
        if (rd_issue)  rd_cnt   <= rd_cnt + ADDR_WIDTH'(1);
        if (handshake) beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
      end

      // Output buffer: the skid entry always refills the output register
      // first so beat order is preserved; the skid is never valid while the
      // output register is empty.
      if (handshake) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          skid_valid <= rd_pending;
          if (rd_pending) skid_data <= bus.RAM_Data;
        end else begin
          out_valid <= rd_pending;
          if (rd_pending) out_data <= bus.RAM_Data;
        end
      end else if (rd_pending) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= bus.RAM_Data;
        end else begin
          skid_valid <= 1'b1;
          skid_data  <= bus.RAM_Data;
        end
      end
    end
  end

  assign bus.RAM_Read_Address = BIT_REVERSE ? {<<{rd_cnt}} : rd_cnt;
  assign bus.RAM_Read_Enable  = rd_issue;
  assign bus.T_VALID          = out_valid;
  assign bus.T_DATA           = out_data;
  assign bus.T_LAST           = out_valid & (beat_cnt == LAST_IDX);
  assign bus.Busy             = (state != IDLE);
  assign bus.Frame_Done       = frame_done_q;
  assign bus.Frame_Dropped    = frame_dropped_q;

endmodule

// File: tb/tb_frame_ram_streamer.sv
// tb_frame_ram_streamer
//   Drives two streamers (BIT_REVERSE 0 and 1) from RAM models holding
//   RAM[i] = i. Expected beats are queued when a frame is started and
//   compared as each beat is handshaken. Inputs change on the falling edge;
//   outputs are sampled 1 ns later.
module tb_frame_ram_streamer;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int N  = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_b     = 1'b1;
  logic frame_ready = 1'b0;
  logic t_ready     = 1'b0;
  logic sel         = 1'b0;

  frame_ram_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  frame_ram_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  frame_ram_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIT_REVERSE(1'b0)) dut0 (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus0.master)
  );

  frame_ram_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIT_REVERSE(1'b1)) dut1 (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus1.master)
  );

  assign bus0.Frame_Ready = frame_ready & ~sel;
  assign bus1.Frame_Ready = frame_ready & sel;
  assign bus0.T_READY     = t_ready;
  assign bus1.T_READY     = t_ready;

  // Frame RAM models: RAM[i] = i, one cycle read latency.
  logic [DW-1:0] ram0_q = '0;
  logic [DW-1:0] ram1_q = '0;
  always @(posedge clk) if (bus0.RAM_Read_Enable) ram0_q <= DW'(bus0.RAM_Read_Address);
  always @(posedge clk) if (bus1.RAM_Read_Enable) ram1_q <= DW'(bus1.RAM_Read_Address);
  assign bus0.RAM_Data = ram0_q;
  assign bus1.RAM_Data = ram1_q;

  // Outputs of the streamer under test.
  logic          m_valid, m_last, m_busy, m_rd_en, m_done, m_dropped;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  assign m_valid   = sel ? bus1.T_VALID         : bus0.T_VALID;
  assign m_data    = sel ? bus1.T_DATA          : bus0.T_DATA;
  assign m_last    = sel ? bus1.T_LAST          : bus0.T_LAST;
  assign m_busy    = sel ? bus1.Busy            : bus0.Busy;
  assign m_rd_en   = sel ? bus1.RAM_Read_Enable : bus0.RAM_Read_Enable;
  assign m_addr    = sel ? bus1.RAM_Read_Address: bus0.RAM_Read_Address;
  assign m_done    = sel ? bus1.Frame_Done      : bus0.Frame_Done;
  assign m_dropped = sel ? bus1.Frame_Dropped   : bus0.Frame_Dropped;

  beat_t         exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            beats, first_hs, last_hs, done_cnt, done_cyc, drop_cnt, drop_cyc, fr_cyc;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_stats();
    beats    = 0;
    first_hs = 0;
    last_hs  = 0;
    done_cnt = 0;
    done_cyc = 0;
    drop_cnt = 0;
    drop_cyc = 0;
  endtask

  // Queue the 64 beats of one frame; rev selects bit-reversed read order.
  task automatic push_frame(input bit rev);
    beat_t         b;
    logic [AW-1:0] idx, r;
    for (int i = 0; i < N; i++) begin
      idx = AW'(i);
      for (int k = 0; k < AW; k++) r[k] = idx[AW-1-k];
      b.data = DW'(rev ? r : idx);
      b.last = (i == N - 1);
      exp_q.push_back(b);
    end
  endtask

  // One clock: drive inputs at the falling edge, then observe. A beat seen
  // valid with ready set is taken at the next rising edge.
  task automatic cycle(input logic fr, input logic rdy, input logic rst);
    beat_t e;
    @(negedge clk);
    frame_ready = fr;
    t_ready     = rdy;
    reset_b     = rst;
    #1;
    cyc++;
    if (m_done)    begin done_cnt++; done_cyc = cyc; end
    if (m_dropped) begin drop_cnt++; drop_cyc = cyc; end
    if (prev_stall) begin
      check("stall_valid_held", 32'(m_valid), 32'd1);
      check("stall_data_held", m_data, prev_data);
      check("stall_last_held", 32'(m_last), 32'(prev_last));
    end
    prev_stall = m_valid & ~rdy & ~rst;
    prev_data  = m_data;
    prev_last  = m_last;
    if (m_valid && rdy && !rst) begin
      check("beat_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("beat%0d_data", beats), m_data, e.data);
        check($sformatf("beat%0d_last", beats), 32'(m_last), 32'(e.last));
      end
      if (beats == 0) first_hs = cyc;
      last_hs = cyc;
      beats++;
    end
  endtask

  // Stream until one more Frame_Done is seen, bounded by max_cyc cycles.
  task automatic run_until_done(input int max_cyc, input bit rand_rdy);
    int   start;
    logic r;
    start = done_cnt;
    for (int i = 0; i < max_cyc && done_cnt == start; i++) begin
      r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(1'b0, r, 1'b0);
    end
    check("frame_done_within_budget", done_cnt - start, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    clear_stats();

    // Reset state.
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    check("rst_t_valid", 32'(bus0.T_VALID), 32'd0);
    check("rst_t_last", 32'(bus0.T_LAST), 32'd0);
    check("rst_t_data", bus0.T_DATA, 32'd0);
    check("rst_rd_en", 32'(bus0.RAM_Read_Enable), 32'd0);
    check("rst_rd_addr", 32'(bus0.RAM_Read_Address), 32'd0);
    check("rst_busy", 32'(bus0.Busy), 32'd0);
    check("rst_done", 32'(bus0.Frame_Done), 32'd0);
    check("rst_dropped", 32'(bus0.Frame_Dropped), 32'd0);
    check("rst_busy_rev", 32'(bus1.Busy), 32'd0);

    // Full-rate frame: latency, 64 consecutive beats, T_LAST, Frame_Done.
    clear_stats();
    push_frame(1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    fr_cyc = cyc;
    cycle(1'b0, 1'b1, 1'b0);
    check("lat_after_e_valid", 32'(m_valid), 32'd0);
    check("lat_after_e_busy", 32'(m_busy), 32'd1);
    check("lat_after_e_rd_en", 32'(m_rd_en), 32'd1);
    check("lat_after_e_addr", 32'(m_addr), 32'd0);
    cycle(1'b0, 1'b1, 1'b0);
    check("lat_after_e1_valid", 32'(m_valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b0);
    check("lat_after_e2_valid", 32'(m_valid), 32'd1);
    check("lat_after_e2_data", m_data, 32'd0);
    run_until_done(200, 1'b0);
    idle(3);
    check("a_first_beat_latency", first_hs - fr_cyc, 3);
    check("a_consecutive_span", last_hs - first_hs, N - 1);
    check("a_beat_count", beats, N);
    check("a_done_after_last_hs", done_cyc - last_hs, 1);
    check("a_done_pulse_count", done_cnt, 1);
    check("a_queue_empty", exp_q.size(), 0);
    check("a_busy_after", 32'(m_busy), 32'd0);
    check("a_rd_en_idle", 32'(m_rd_en), 32'd0);

    // Random backpressure: same sequence, no loss, no duplication.
    clear_stats();
    push_frame(1'b0);
    cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    run_until_done(800, 1'b1);
    idle(3);
    check("b_beat_count", beats, N);
    check("b_queue_empty", exp_q.size(), 0);
    check("b_done_pulse_count", done_cnt, 1);
    check("b_drop_count", drop_cnt, 0);

    // Drop at beat 20, then back-to-back frame on the final handshake.
    clear_stats();
    push_frame(1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 200 && beats < 20; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    fr_cyc = cyc;
    cycle(1'b0, 1'b1, 1'b0);
    check("d_dropped_pulse", 32'(m_dropped), 32'd1);
    cycle(1'b0, 1'b1, 1'b0);
    check("d_dropped_cleared", 32'(m_dropped), 32'd0);
    check("d_drop_cycle", drop_cyc - fr_cyc, 1);
    for (int i = 0; i < 200 && beats < N - 1; i++) cycle(1'b0, 1'b1, 1'b0);
    push_frame(1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("d_fr_on_last_beat", 32'(m_valid & m_last), 32'd1);
    cycle(1'b0, 1'b1, 1'b0);
    check("d_done_on_chain", 32'(m_done), 32'd1);
    check("d_busy_on_chain", 32'(m_busy), 32'd1);
    check("d_no_drop_on_chain", 32'(m_dropped), 32'd0);
    run_until_done(200, 1'b0);
    idle(3);
    check("d_drop_count", drop_cnt, 1);
    check("d_done_count", done_cnt, 2);
    check("d_beat_count", beats, 2 * N);
    check("d_queue_empty", exp_q.size(), 0);

    // Bit-reversed order on the second streamer.
    sel = 1'b1;
    clear_stats();
    push_frame(1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    run_until_done(200, 1'b0);
    idle(3);
    check("c_beat_count", beats, N);
    check("c_queue_empty", exp_q.size(), 0);
    check("c_done_count", done_cnt, 1);
    sel = 1'b0;

    // Reset mid-frame while stalled at beat 30, with Frame_Ready also high.
    clear_stats();
    push_frame(1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 200 && beats < 30; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("e_stalled_valid", 32'(m_valid), 32'd1);
    check("e_stalled_data", m_data, 32'd30);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check("e_rst_valid", 32'(m_valid), 32'd0);
    check("e_rst_busy", 32'(m_busy), 32'd0);
    check("e_rst_rd_en", 32'(m_rd_en), 32'd0);
    check("e_rst_last", 32'(m_last), 32'd0);
    exp_q.delete();
    idle(4);
    check("e_aborted_beats", beats, 30);
    check("e_aborted_no_done", done_cnt, 0);
    clear_stats();
    push_frame(1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    run_until_done(200, 1'b0);
    idle(3);
    check("e_new_beat_count", beats, N);
    check("e_new_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
